// File: rtl/tcp_msg_req_enqueue_ctrl.sv
// App-side producer for the TCP message-request poller: claims a flow's active bit,
// writes the requested length to the request memory, then pushes the flow ID to the poll queue.
module tcp_msg_req_enqueue_ctrl #(
  parameter int FLOWID_W  = 6,
  parameter int MSG_LEN_W = 32
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     app_req_val,
  output logic                     app_req_rdy,
  input  logic [FLOWID_W-1:0]      app_req_flowid,
  input  logic [MSG_LEN_W-1:0]     app_req_len,
  output logic                     enq_msg_req_mem_wr_req_val,
  input  logic                     msg_req_mem_enq_wr_req_rdy,
  output logic [FLOWID_W-1:0]      enq_msg_req_mem_wr_req_addr,
  output logic [MSG_LEN_W-1:0]     enq_msg_req_mem_wr_req_data,
  output logic                     enq_msg_req_q_wr_req_val,
  input  logic                     msg_req_q_enq_wr_req_rdy,
  output logic [FLOWID_W-1:0]      enq_msg_req_q_wr_req_data,
  input  logic                     poll_active_bitvec_clear_req_val,
  input  logic [FLOWID_W-1:0]      poll_active_bitvec_clear_flowid,
  output logic                     app_resp_val,
  input  logic                     app_resp_rdy,
  output logic                     app_resp_accepted,
  output logic [FLOWID_W-1:0]      app_resp_flowid,
  output logic [(2**FLOWID_W)-1:0] active_bitvec
);

  localparam int NUM_FLOWS = 2**FLOWID_W;

  typedef enum logic [2:0] {
    S_READY  = 3'd0,
    S_CHK    = 3'd1,
    S_WR_MEM = 3'd2,
    S_ENQ    = 3'd3,
    S_RESP   = 3'd4
  } state_t;

  state_t                 r_state;
  logic [NUM_FLOWS-1:0]   r_bitvec;
  logic [FLOWID_W-1:0]    r_flow;
  logic [MSG_LEN_W-1:0]   r_len;
  logic                   r_accepted;
  logic                   r_req_rdy;
  logic                   r_mem_val;
  logic                   r_q_val;
  logic                   r_resp_val;

  logic                   w_active;
  logic                   w_set;
  logic [NUM_FLOWS-1:0]   w_bitvec_next;

  // A poller clear landing in the check cycle frees the flow for this request.
  assign w_active = r_bitvec[r_flow] &
                    ~(poll_active_bitvec_clear_req_val &&
                      (poll_active_bitvec_clear_flowid == r_flow));

  // Clear first, then set, so a same-flow set/clear collision leaves the bit set.
  always_comb begin
    w_set         = (r_state == S_CHK) && !w_active;
    w_bitvec_next = r_bitvec;
    if (poll_active_bitvec_clear_req_val)
      w_bitvec_next[poll_active_bitvec_clear_flowid] = 1'b0;
    if (w_set)
      w_bitvec_next[r_flow] = 1'b1;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state    <= S_READY;
      r_bitvec   <= '0;
      r_flow     <= '0;
      r_len      <= '0;
      r_accepted <= 1'b0;
      r_req_rdy  <= 1'b1;
      r_mem_val  <= 1'b0;
      r_q_val    <= 1'b0;
      r_resp_val <= 1'b0;
    end else begin
      r_bitvec <= w_bitvec_next;
      case (r_state)
        S_READY: begin
          r_req_rdy  <= 1'b1;
          r_mem_val  <= 1'b0;
          r_q_val    <= 1'b0;
          r_resp_val <= 1'b0;
          if (app_req_val && app_req_rdy) begin
            r_flow    <= app_req_flowid;
            r_len     <= app_req_len;
            r_req_rdy <= 1'b0;
            r_state   <= S_CHK;
          end
        end
        S_CHK: begin
          if (w_active) begin
            r_accepted <= 1'b0;
            r_resp_val <= 1'b1;
            r_state    <= S_RESP;
          end else begin
            r_accepted <= 1'b1;
            r_mem_val  <= 1'b1;
            r_state    <= S_WR_MEM;
          end
        end
        S_WR_MEM: begin
          if (msg_req_mem_enq_wr_req_rdy) begin
            r_mem_val <= 1'b0;
            r_q_val   <= 1'b1;
            r_state   <= S_ENQ;
          end
        end
        S_ENQ: begin
          if (msg_req_q_enq_wr_req_rdy) begin
            r_q_val    <= 1'b0;
            r_resp_val <= 1'b1;
            r_state    <= S_RESP;
          end
        end
        S_RESP: begin
          if (app_resp_rdy) begin
            r_resp_val <= 1'b0;
            r_req_rdy  <= 1'b1;
            r_state    <= S_READY;
          end
        end
        default: begin
          r_req_rdy  <= 1'bx;
          r_mem_val  <= 1'bx;
          r_q_val    <= 1'bx;
          r_resp_val <= 1'bx;
          r_accepted <= 1'bx;
          r_state    <= S_READY;
        end
      endcase
    end
  end

  // Ready is gated by reset so it reads low for the whole reset window.
  assign app_req_rdy                 = r_req_rdy & rst;
  assign enq_msg_req_mem_wr_req_val  = r_mem_val;
  assign enq_msg_req_mem_wr_req_addr = r_flow;
  assign enq_msg_req_mem_wr_req_data = r_len;
  assign enq_msg_req_q_wr_req_val    = r_q_val;
  assign enq_msg_req_q_wr_req_data   = r_flow;
  assign app_resp_val                = r_resp_val;
  assign app_resp_accepted           = r_accepted;
  assign app_resp_flowid             = r_flow;
  assign active_bitvec               = r_bitvec;

endmodule

// File: doc/tcp_msg_req_enqueue_ctrl.md
Name: tcp_msg_req_enqueue_ctrl

Overview:
- App-side producer for the TCP message-request poller.
- Accepts an application "notify me when N bytes are available on flow F" request.
- Writes the requested length into the message-request memory, then pushes the flow ID onto the message-request queue that the poller drains.
- Owns the per-flow active bitvector, which the poller clears once a request is satisfied. This guarantees at most one outstanding request per flow.

Parameters:
- FLOWID_W, 6, flow ID width; NUM_FLOWS = 2**FLOWID_W.
- MSG_LEN_W, 32, requested message length width in bytes.

Ports:
- clk  in  1  clock
- rst  in  1  reset; asynchronous, active-low
- app_req_val  in  1  app request valid
- app_req_rdy  out  1  block can accept a request
- app_req_flowid  in  FLOWID_W  target flow
- app_req_len  in  MSG_LEN_W  bytes required before notification
- enq_msg_req_mem_wr_req_val  out  1  message-request memory write valid
- msg_req_mem_enq_wr_req_rdy  in  1  memory write ready
- enq_msg_req_mem_wr_req_addr  out  FLOWID_W  write address (flow ID)
- enq_msg_req_mem_wr_req_data  out  MSG_LEN_W  write data (length)
- enq_msg_req_q_wr_req_val  out  1  request-queue push valid
- msg_req_q_enq_wr_req_rdy  in  1  queue push ready (not full)
- enq_msg_req_q_wr_req_data  out  FLOWID_W  flow ID pushed
- poll_active_bitvec_clear_req_val  in  1  poller clears an active bit
- poll_active_bitvec_clear_flowid  in  FLOWID_W  flow to clear
- app_resp_val  out  1  response valid
- app_resp_rdy  in  1  app accepts response
- app_resp_accepted  out  1  1 = enqueued, 0 = busy (flow already has a pending request)
- app_resp_flowid  out  FLOWID_W  flow ID echoed from the request
- active_bitvec  out  NUM_FLOWS  current active bits (debug/status)

Behaviour:
- Reset (rst low, async):
  - state = READY; bitvec all 0; flow/len registers 0.
  - All val outputs 0; app_resp_accepted 0.
  - app_req_rdy is 0 while in reset.
- READY:
  - app_req_rdy = 1.
  - On app_req_val & app_req_rdy: latch flowid and len; go to CHK.
- CHK (single cycle):
  - active = bitvec[flow] & ~(clear_val & clear_flowid == flow). A clear arriving in this same cycle bypasses, so the flow counts as inactive.
  - If active: resp_accepted_reg = 0; go to RESP.
  - Else: set bitvec[flow] at this clock edge; resp_accepted_reg = 1; go to WR_MEM.
- WR_MEM:
  - mem wr val = 1; addr = flow; data = len.
  - Hold val, addr and data stable until rdy, then go to ENQ.
  - The memory write always precedes the queue push, so the poller never reads a stale length.
- ENQ:
  - q wr val = 1; data = flow.
  - Hold until rdy (queue full stalls here), then go to RESP.
- RESP:
  - app_resp_val = 1; accepted and flowid are stable.
  - Hold until app_resp_rdy, then go to READY.
  - No new request is accepted while outside READY.
- Bitvector update every cycle, in any state:
  - clear_val clears bit clear_flowid.
  - Clearing an already-0 bit has no effect.
  - If a set (CHK, inactive path) and a clear target the same flow in the same cycle, the set wins (final bit = 1).
  - A clear of a different flow proceeds independently of a set.
- Latency (all rdy high):
  - Accepted: request handshake at cycle 0, CHK cycle 1, WR_MEM cycle 2, ENQ cycle 3, app_resp_val at cycle 4.
  - Busy: app_resp_val at cycle 2.
  - Back-to-back throughput: one request per 5 cycles (accepted) or 3 cycles (busy).
- Illegal state encodings drive X on outputs and go to READY.
- Reset asserted mid-operation: immediate return to READY with bitvec cleared; any partial mem write or queue push is abandoned (val drops asynchronously).

Test Plan:
- Reset, then req flow 5 len 1000, all rdy=1 -> mem write addr 5 data 1000 at cycle 2, queue push 5 at cycle 3, resp accepted=1 flowid 5 at cycle 4; active_bitvec[5]=1.
- Repeat req flow 5 len 200 without a clear -> no mem write, no push; resp accepted=0 at cycle 2; bit 5 stays 1.
- Clear flow 5 asserted in the same cycle as CHK for a new flow-5 request -> accepted=1; bit 5 ends at 1; mem write data 200.
- msg_req_q_enq_wr_req_rdy held low 10 cycles in ENQ -> wr val and data=flow stay stable for all 10 cycles; resp only after rdy rises; app_req_rdy=0 throughout.
- mem wr rdy low 3 cycles, app_resp_rdy low 4 cycles -> addr/data stable while stalled; resp_val held 4 cycles; exactly one push.
- Async reset pulse during WR_MEM for flow 9 -> all vals drop immediately; after release bitvec=0, state READY; a new flow-9 request is accepted=1.
